clock_gated_prod_accumulator: RTL

Downstream stage of the 4-bit clock-gated multiplier. It samples the multiplier's registered 8-bit product on the rising clock edge, half a cycle after the multiplier's falling-edge update. It accumulates N_ACC consecutive valid products into one sum and presents that sum with a valid/ready handshake. It also drives the multiplier's clock-enable, so the multiplier stops switching while this stage is back-pressured.

---
 rtl/clock_gated_prod_accumulator_pkg.sv | 30 +++
 rtl/clock_gated_prod_accumulator.sv | 117 +++++++++++
 2 files changed

// File: rtl/clock_gated_prod_accumulator_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : clock_gated_prod_accumulator_pkg                             |
// | Description : Shared state encoding, default product width and a ceil-log2 |
// |               helper for the clock-gated product accumulator.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package clock_gated_prod_accumulator_pkg;

  // Width of the product delivered by the 4-bit multiplier
  localparam int C_PROD_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Ceiling log2; used for counter and sum widths at elaboration time
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clock_gated_prod_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : clock_gated_prod_accumulator                                 |
// | Description : Sums N_ACC consecutive multiplier products and offers the    |
// |               sum on a valid/ready port. Drives the multiplier clock       |
// |               enable so the multiplier idles while the result is held.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module clock_gated_prod_accumulator
  import clock_gated_prod_accumulator_pkg::*;
#(
  parameter int PROD_W = C_PROD_W_DEF,
  parameter int N_ACC  = 4,
  parameter int ACC_W  = PROD_W + clog2(N_ACC),
  localparam int CNT_W = clog2(N_ACC)
) (
  input  logic              clk,
  input  logic              rst,          // asynchronous, active-low
  input  logic              i_clear,
  input  logic              i_in_valid,
  input  logic [PROD_W-1:0] i_in_prod,
  output logic              o_in_ready,
  output logic              o_mult_en,
  output logic [ACC_W-1:0]  o_sum_out,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [CNT_W-1:0]  o_cnt
);

  // A batch of fewer than two products is meaningless for this stage
  generate
    if (N_ACC < 2) begin : g_bad_n_acc
      $error("clock_gated_prod_accumulator: N_ACC must be at least 2");
    end
  endgenerate

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(N_ACC - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [ACC_W-1:0]   r_sum;
  logic               r_out_valid;

  logic [ACC_W-1:0]   w_prod_ext;
  logic [ACC_W-1:0]   w_acc_next;
  logic               w_in_ready;
  logic               w_accept;

  // Ready depends on state alone, so no combinational path from o_out_ready
  assign w_in_ready = (r_state != ST_HOLD);
  assign w_accept   = i_in_valid & w_in_ready;
  assign w_prod_ext = {{(ACC_W - PROD_W){1'b0}}, i_in_prod};
  assign w_acc_next = r_acc + w_prod_ext;

  // Batch FSM: collect products, publish the sum, wait for the consumer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_out_valid <= 1'b0;
    end else if (i_clear) begin
      // Flush wins over any accept or handshake; last sum is left visible
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_acc   <= w_prod_ext;
            r_cnt   <= C_CNT_ONE;
            r_state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (w_accept) begin
            if (r_cnt == C_CNT_LAST) begin
              r_sum       <= w_acc_next;
              r_out_valid <= 1'b1;
              r_acc       <= '0;
              r_cnt       <= '0;
              r_state     <= ST_HOLD;
            end else begin
              r_acc <= w_acc_next;
              r_cnt <= r_cnt + C_CNT_ONE;
            end
          end
        end
        ST_HOLD: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_acc       <= '0;
          r_cnt       <= '0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_mult_en   = w_in_ready;
  assign o_sum_out   = r_sum;
  assign o_out_valid = r_out_valid;
  assign o_cnt       = r_cnt;

endmodule
`default_nettype wire
